armleocpu_axi_read_responder: RTL and testbench

- AXI4 read-channel responder (AR/R only): serves read bursts from initiators such as the page table walker and the instruction/data caches.
- Translates each beat into a single-word read on a simple synchronous memory port (SRAM or boot ROM).
- Used as the memory model in cache/PTW testbenches and as the boot ROM front end in the SoC.
- Handles FIXED/INCR/WRAP bursts, out-of-range decode errors and malformed-request slave errors.

---
 rtl/armleocpu_axi_pkg.sv | 35 +++
 rtl/armleocpu_axi_burst_addr_gen.sv | 30 +++
 rtl/armleocpu_axi_read_responder.sv | 145 ++++++++++++++
 tb/tb_armleocpu_axi_read_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_axi_pkg.sv
// Shared AXI encodings and read-responder state type.
// Holds the burst-legality helper used at AR acceptance.
package armleocpu_axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_MEM  = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

  // A request is malformed if it is not a word-sized, word-aligned beat of a
  // legal burst type; WRAP additionally needs a power-of-two length of 2..16.
  function automatic logic axi_burst_err(input logic [2:0] size,
                                         input logic [1:0] burst,
                                         input logic [7:0] len,
                                         input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (size != 3'd2) err = 1'b1;
    if (burst == 2'b11) err = 1'b1;
    if (burst == AXI_BURST_WRAP &&
        !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
    if (addr_lo != 2'b00) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/armleocpu_axi_burst_addr_gen.sv
// Combinational next-beat byte address for 4-byte AXI beats.
// Shared between the read responder and a future write responder.
module armleocpu_axi_burst_addr_gen
  import armleocpu_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 34
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign incr_addr = addr + ADDR_WIDTH'(4);
  // span - 1 = 4*(len+1) - 1 = {len, 2'b11}
  assign wrap_mask = ADDR_WIDTH'({len, 2'b11});

  always_comb begin
    next_addr = addr;
    case (burst)
      AXI_BURST_INCR: next_addr = incr_addr;
      AXI_BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:        next_addr = addr;
    endcase
  end

endmodule

// File: rtl/armleocpu_axi_read_responder.sv
// AXI4 AR/R responder in front of a single-port synchronous word memory.
// Optional macro ARMLEOCPU_AXI_READ_RESPONDER_ERRINJ_EN adds the err_inject input.
module armleocpu_axi_read_responder
  import armleocpu_axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 34,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = '0,
  parameter int                    MEM_WORDS_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  input  logic [ADDR_WIDTH-1:0]     axi_araddr,
  input  logic [7:0]                axi_arlen,
  input  logic [2:0]                axi_arsize,
  input  logic [1:0]                axi_arburst,
`ifdef ARMLEOCPU_AXI_READ_RESPONDER_ERRINJ_EN
  input  logic                      err_inject,
`endif
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rlast,
  output logic [31:0]               axi_rdata,
  output logic                      mem_read,
  output logic [MEM_WORDS_LOG2-1:0] mem_addr,
  input  logic [31:0]               mem_rdata,
  output rd_state_t                 dbg_state
);

  // Handshakes: AR transfers on a rising edge with arvalid & arready; R
  // transfers on a rising edge with rvalid & rready, and every R output is
  // held unchanged while rvalid=1 and rready=0.

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  inject;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  in_range;
  logic [1:0]            beat_resp;

`ifdef ARMLEOCPU_AXI_READ_RESPONDER_ERRINJ_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  armleocpu_axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Range is judged per beat, so INCR bursts may run off the end into DECERR.
  assign offset    = addr_q - MEM_BASE;
  assign word_off  = offset >> 2;
  assign in_range  = (addr_q >= MEM_BASE) && (word_off[ADDR_WIDTH-1:MEM_WORDS_LOG2] == '0);
  assign beat_resp = err_q     ? AXI_RESP_SLVERR :
                     !in_range ? AXI_RESP_DECERR : AXI_RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rresp   = AXI_RESP_OKAY;
    axi_rlast   = 1'b0;
    axi_rdata   = '0;
    mem_read    = 1'b0;
    mem_addr    = '0;
    case (state_q)
      RD_IDLE: begin
        // Gated by rst_n so arready is 0 for the whole reset assertion.
        axi_arready = rst_n;
        if (axi_arvalid) begin
          addr_d  = axi_araddr;
          len_d   = axi_arlen;
          burst_d = axi_arburst;
          cnt_d   = axi_arlen;
          err_d   = axi_burst_err(axi_arsize, axi_arburst, axi_arlen, axi_araddr[1:0]) | inject;
          state_d = RD_MEM;
        end
      end
      RD_MEM: begin
        if (in_range && !err_q) begin
          mem_read = 1'b1;
          mem_addr = word_off[MEM_WORDS_LOG2-1:0];
        end
        state_d = RD_RESP;
      end
      RD_RESP: begin
        axi_rvalid = 1'b1;
        axi_rlast  = (cnt_q == 8'd0);
        axi_rresp  = beat_resp;
        axi_rdata  = (beat_resp == AXI_RESP_OKAY) ? mem_rdata : 32'h0;
        if (axi_rready) begin
          if (cnt_q == 8'd0) begin
            state_d = RD_IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = next_addr;
            state_d = RD_MEM;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_armleocpu_axi_read_responder.sv
// Directed bench for armleocpu_axi_read_responder with a synchronous memory model.
module tb_armleocpu_axi_read_responder;
  import armleocpu_axi_pkg::*;

  localparam int AW = 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          axi_arvalid, axi_arready;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_rvalid, axi_rready, axi_rlast;
  logic [1:0]    axi_rresp;
  logic [31:0]   axi_rdata;
  logic          mem_read;
  logic [9:0]    mem_addr;
  logic [31:0]   mem_rdata;
  rd_state_t     dbg_state;
`ifdef ARMLEOCPU_AXI_READ_RESPONDER_ERRINJ_EN
  logic          err_inject = 1'b0;
`endif

  armleocpu_axi_read_responder #(
    .ADDR_WIDTH     (AW),
    .MEM_BASE       ('0),
    .MEM_WORDS_LOG2 (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
`ifdef ARMLEOCPU_AXI_READ_RESPONDER_ERRINJ_EN
    .err_inject  (err_inject),
`endif
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rdata   (axi_rdata),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .dbg_state   (dbg_state)
  );

  // Memory model: word i holds 0xC0DE0000 | i, except word 0x40 = 0xDEADBEEF.
  logic [31:0] mem [0:1023];
  always_ff @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- captured beats ----------------
  logic [31:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [9:0]  got_maddr[$];
  logic [31:0] exp_q[$];
  int          first_mem_cyc, first_rv_cyc, busy_arready, stall_bad;
  bit          hs_ok, done_ok;

  // ---------------- driver tasks ----------------
  task automatic start_ar(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    hs_ok = 1'b0;
    @(negedge clk);
    axi_arvalid = 1'b1;
    axi_araddr  = addr;
    axi_arlen   = len;
    axi_arsize  = size;
    axi_arburst = burst;
    for (int w = 0; w < 10; w++) begin
      if (axi_arready) begin
        hs_ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 axi_arvalid = 1'b0;
  endtask

  // Collects beats until rlast; optionally holds rready low for 5 cycles on beat stall_beat.
  task automatic collect(input int stall_beat);
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    logic        s_last;
    got_data.delete(); got_resp.delete(); got_last.delete(); got_maddr.delete();
    first_mem_cyc = -1; first_rv_cyc = -1; busy_arready = 0; stall_bad = 0;
    done_ok = 1'b0;
    axi_rready = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (axi_arready) busy_arready++;
      if (mem_read) begin
        got_maddr.push_back(mem_addr);
        if (first_mem_cyc < 0) first_mem_cyc = c;
      end
      if (axi_rvalid) begin
        if (first_rv_cyc < 0) first_rv_cyc = c;
        if (got_data.size() == stall_beat) begin
          s_data = axi_rdata; s_resp = axi_rresp; s_last = axi_rlast;
          axi_rready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            if (axi_rvalid !== 1'b1 || axi_rdata !== s_data ||
                axi_rresp !== s_resp || axi_rlast !== s_last) stall_bad++;
            if (mem_read) stall_bad++;
            if (axi_arready) busy_arready++;
          end
          axi_rready = 1'b1;
        end
        got_data.push_back(axi_rdata);
        got_resp.push_back(axi_rresp);
        got_last.push_back(axi_rlast);
        if (axi_rlast) begin
          done_ok = 1'b1;
          break;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (axi_arready !== 1'b0) $display("FAIL reset_arready: got %b expected 0", axi_arready); else n_pass++;
    n_checks++; if (axi_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", axi_rvalid); else n_pass++;
    n_checks++; if (mem_read !== 1'b0 || axi_rdata !== 32'h0) $display("FAIL reset_outs: mem_read %b rdata %h expected 0 0", mem_read, axi_rdata); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (axi_arready !== 1'b1) $display("FAIL post_reset_arready: got %b expected 1", axi_arready); else n_pass++;
    n_checks++; if (dbg_state !== RD_IDLE) $display("FAIL post_reset_state: got %0d expected %0d", dbg_state, RD_IDLE); else n_pass++;
  endtask

  task automatic test_single_beat();
    start_ar(34'h100, 8'd0, 3'd2, AXI_BURST_INCR);
    collect(-1);
    n_checks++; if (!(hs_ok && done_ok)) $display("FAIL single_timeout: hs %b done %b expected 1 1", hs_ok, done_ok); else n_pass++;
    n_checks++; if (first_mem_cyc !== 1) $display("FAIL single_memread_lat: got %0d expected 1", first_mem_cyc); else n_pass++;
    n_checks++; if (first_rv_cyc !== 2) $display("FAIL single_rvalid_lat: got %0d expected 2", first_rv_cyc); else n_pass++;
    n_checks++; if (got_maddr.size() !== 1 || got_maddr[0] !== 10'h40) $display("FAIL single_maddr: got %0d reads first %h expected 1 read of 040", got_maddr.size(), got_maddr[0]); else n_pass++;
    n_checks++; if (got_data.size() !== 1 || got_data[0] !== 32'hDEADBEEF) $display("FAIL single_rdata: got %h expected deadbeef", got_data[0]); else n_pass++;
    n_checks++; if (got_resp[0] !== AXI_RESP_OKAY || got_last[0] !== 1'b1) $display("FAIL single_resp_last: got %b %b expected 00 1", got_resp[0], got_last[0]); else n_pass++;
  endtask

  task automatic test_incr();
    start_ar(34'h0, 8'd3, 3'd2, AXI_BURST_INCR);
    collect(-1);
    exp_q = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    n_checks++; if (got_maddr.size() !== 4 || got_data.size() !== 4) $display("FAIL incr_count: got %0d reads %0d beats expected 4 4", got_maddr.size(), got_data.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_maddr[i] !== 10'(i)) $display("FAIL incr_maddr%0d: got %h expected %h", i, got_maddr[i], 10'(i)); else n_pass++;
      n_checks++; if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 3)) $display("FAIL incr_beat%0d: got %h last %b expected %h last %b", i, got_data[i], got_last[i], exp_q[i], (i == 3)); else n_pass++;
    end
    n_checks++; if (busy_arready !== 0) $display("FAIL incr_arready_busy: got %0d cycles expected 0", busy_arready); else n_pass++;
  endtask

  task automatic test_wrap();
    start_ar(34'h8, 8'd3, 3'd2, AXI_BURST_WRAP);
    collect(-1);
    exp_q = '{32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0000, 32'hC0DE0001};
    n_checks++; if (got_maddr.size() !== 4) $display("FAIL wrap_count: got %0d expected 4", got_maddr.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (got_maddr[i] !== exp_q[i][9:0] || got_data[i] !== exp_q[i]) $display("FAIL wrap_beat%0d: got addr %h data %h expected %h %h", i, got_maddr[i], got_data[i], exp_q[i][9:0], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_fixed();
    start_ar(34'h10, 8'd2, 3'd2, AXI_BURST_FIXED);
    collect(-1);
    n_checks++; if (got_maddr.size() !== 3) $display("FAIL fixed_count: got %0d expected 3", got_maddr.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (got_maddr[i] !== 10'h4 || got_data[i] !== 32'hC0DE0004) $display("FAIL fixed_beat%0d: got %h %h expected 004 c0de0004", i, got_maddr[i], got_data[i]); else n_pass++;
    end
  endtask

  task automatic test_slverr();
    // WRAP len 2, arsize 3, misaligned address, reserved burst type
    logic [AW-1:0] a_t[4] = '{34'h0, 34'h0, 34'h2, 34'h0};
    logic [7:0]    l_t[4] = '{8'd2, 8'd0, 8'd1, 8'd0};
    logic [2:0]    s_t[4] = '{3'd2, 3'd3, 3'd2, 3'd2};
    logic [1:0]    b_t[4] = '{AXI_BURST_WRAP, AXI_BURST_INCR, AXI_BURST_INCR, 2'b11};
    for (int v = 0; v < 4; v++) begin
      start_ar(a_t[v], l_t[v], s_t[v], b_t[v]);
      collect(-1);
      n_checks++; if (got_data.size() !== int'(l_t[v]) + 1) $display("FAIL slverr%0d_beats: got %0d expected %0d", v, got_data.size(), int'(l_t[v]) + 1); else n_pass++;
      n_checks++; if (got_maddr.size() !== 0) $display("FAIL slverr%0d_memread: got %0d expected 0", v, got_maddr.size()); else n_pass++;
      for (int i = 0; i < got_data.size(); i++) begin
        n_checks++; if (got_resp[i] !== AXI_RESP_SLVERR || got_data[i] !== 32'h0) $display("FAIL slverr%0d_beat%0d: got %b %h expected 10 0", v, i, got_resp[i], got_data[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_decerr();
    start_ar(34'h1000, 8'd0, 3'd2, AXI_BURST_INCR);
    collect(-1);
    n_checks++; if (got_resp[0] !== AXI_RESP_DECERR || got_data[0] !== 32'h0 || got_maddr.size() !== 0) $display("FAIL decerr_single: got %b %h reads %0d expected 11 0 0", got_resp[0], got_data[0], got_maddr.size()); else n_pass++;
    start_ar(34'hFFC, 8'd1, 3'd2, AXI_BURST_INCR);
    collect(-1);
    n_checks++; if (got_maddr.size() !== 1 || got_maddr[0] !== 10'h3FF) $display("FAIL edge_maddr: got %0d reads first %h expected 1 read of 3ff", got_maddr.size(), got_maddr[0]); else n_pass++;
    n_checks++; if (got_resp[0] !== AXI_RESP_OKAY || got_data[0] !== 32'hC0DE03FF) $display("FAIL edge_beat0: got %b %h expected 00 c0de03ff", got_resp[0], got_data[0]); else n_pass++;
    n_checks++; if (got_resp[1] !== AXI_RESP_DECERR || got_data[1] !== 32'h0 || got_last[1] !== 1'b1) $display("FAIL edge_beat1: got %b %h %b expected 11 0 1", got_resp[1], got_data[1], got_last[1]); else n_pass++;
  endtask

  task automatic test_backpressure();
    start_ar(34'h0, 8'd3, 3'd2, AXI_BURST_INCR);
    collect(1);
    n_checks++; if (stall_bad !== 0) $display("FAIL bp_stable: got %0d violations expected 0", stall_bad); else n_pass++;
    n_checks++; if (got_maddr.size() !== 4) $display("FAIL bp_reads: got %0d expected 4", got_maddr.size()); else n_pass++;
    n_checks++; if (got_data[1] !== 32'hC0DE0001 || got_data[2] !== 32'hC0DE0002) $display("FAIL bp_data: got %h %h expected c0de0001 c0de0002", got_data[1], got_data[2]); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int seen, stray;
    start_ar(34'h0, 8'd3, 3'd2, AXI_BURST_INCR);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (axi_rvalid) begin seen = 1; break; end
    end
    n_checks++; if (seen !== 1) $display("FAIL rmb_first_beat: got %0d expected 1", seen); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (axi_rvalid !== 1'b0 || axi_arready !== 1'b0) $display("FAIL rmb_async: rvalid %b arready %b expected 0 0", axi_rvalid, axi_arready); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (axi_rvalid || mem_read || axi_arready !== 1'b1) stray++;
    end
    n_checks++; if (stray !== 0) $display("FAIL rmb_abandon: got %0d bad cycles expected 0", stray); else n_pass++;
    start_ar(34'h14, 8'd0, 3'd2, AXI_BURST_INCR);
    collect(-1);
    n_checks++; if (got_data.size() !== 1 || got_data[0] !== 32'hC0DE0005 || got_resp[0] !== AXI_RESP_OKAY) $display("FAIL rmb_after: got %0d beats %h %b expected 1 c0de0005 00", got_data.size(), got_data[0], got_resp[0]); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[10'h40] = 32'hDEADBEEF;
    mem_rdata   = 32'h0;
    axi_arvalid = 1'b0;
    axi_araddr  = '0;
    axi_arlen   = '0;
    axi_arsize  = 3'd2;
    axi_arburst = AXI_BURST_INCR;
    axi_rready  = 1'b1;
    test_reset();
    test_single_beat();
    test_incr();
    test_wrap();
    test_fixed();
    test_slverr();
    test_decerr();
    test_backpressure();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
